// File: rtl/fitbit_display_sequencer_pkg.sv
// Shared fitbit definitions: display selector encodings, the saturation
// limit of the 4-digit display and the half-mile to tenths-of-a-mile factor.
package fitbit_display_sequencer_pkg;

    // Width of the binary value handed to the display driver
    localparam int unsigned DISP_W = 14;

    // Largest value a 4-digit display can show
    localparam int unsigned DISP_SAT_MAX = 9999;

    // Distance arrives in half miles; the display shows tenths of a mile
    localparam int unsigned HALF_MILE_TO_TENTHS = 5;

    // Width used for saturation arithmetic, wide enough for a 32-bit input times 5
    localparam int unsigned WIDE_W = 35;

    // Rotation states double as the selector seen by the display driver
    typedef enum logic [1:0] {
        S_STEPS = 2'd0,
        S_DIST  = 2'd1,
        S_ACT   = 2'd2,
        S_HIGH  = 2'd3
    } disp_state_t;

    // Clamp a wide unsigned value to the display limit
    function automatic logic [DISP_W-1:0] saturate(input logic [WIDE_W-1:0] value,
                                                   input logic [WIDE_W-1:0] limit);
        logic [WIDE_W-1:0] clamped;
        clamped = (value > limit) ? limit : value;
        return clamped[DISP_W-1:0];
    endfunction

    // Fixed rotation order through the four statistics
    function automatic disp_state_t next_in_rotation(input disp_state_t cur);
        disp_state_t nxt;
        case (cur)
            S_STEPS: nxt = S_DIST;
            S_DIST:  nxt = S_ACT;
            S_ACT:   nxt = S_HIGH;
            S_HIGH:  nxt = S_STEPS;
            default: nxt = S_STEPS;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fitbit_sec_timer.sv
// One-second time base for the fitbit: counts CLK cycles and emits a
// single-cycle sec_tick, one cycle after the counter wraps to zero.
module fitbit_sec_timer #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic CLK,
    input  logic RESET,
    output logic sec_tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] tick_count;
    logic             at_last;

    assign at_last = (tick_count == CNT_LAST);

    // Free-running cycle counter; the tick is registered so it lands on the cycle after the wrap
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_count <= '0;
            sec_tick   <= 1'b0;
        end else begin
            sec_tick   <= at_last;
            tick_count <= at_last ? '0 : tick_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fitbit_display_sequencer.sv
// Rotates steps, distance, activity count and high-activity time onto the
// shared 4-digit display, each for a fixed number of seconds. Values are
// clamped to the display range; distance is shown in tenths of a mile with
// the decimal point lit. Value and selector are registered from the same
// next-state decision so they always change together.
module fitbit_display_sequencer
    import fitbit_display_sequencer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned DWELL_SEC     = 2,
    parameter int unsigned SAT_MAX       = DISP_SAT_MAX
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              HOLD,
    input  logic [31:0]       step_count,
    input  logic [31:0]       distance_covered,
    input  logic [3:0]        initial_activity_count,
    input  logic [31:0]       high_activity_time,
    output logic [DISP_W-1:0] disp_value,
    output logic [1:0]        disp_sel,
    output logic              disp_dp,
    output logic              sec_tick
);

    localparam int unsigned DWELL_W = (DWELL_SEC > 1) ? $clog2(DWELL_SEC) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_SEC - 1);
    localparam logic [WIDE_W-1:0]  SAT_LIMIT  = WIDE_W'(SAT_MAX);

    disp_state_t        state_q;
    disp_state_t        state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [DISP_W-1:0]  value_d;
    logic               dp_d;
    logic [WIDE_W-1:0]  dist_tenths;

    fitbit_sec_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .sec_tick (sec_tick)
    );

    // Distance scaled in full width so huge inputs clamp rather than wrap
    assign dist_tenths = {3'b000, distance_covered} * WIDE_W'(HALF_MILE_TO_TENTHS);

    // Rotation decision: seconds accumulate in the dwell counter unless HOLD freezes them
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (sec_tick && !HOLD) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                state_d = next_in_rotation(state_q);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // Display value for the state being entered, so value and selector stay paired
    always_comb begin
        value_d = '0;
        dp_d    = 1'b0;
        case (state_d)
            S_STEPS: value_d = saturate({3'b000, step_count}, SAT_LIMIT);
            S_DIST: begin
                value_d = saturate(dist_tenths, SAT_LIMIT);
                dp_d    = 1'b1;
            end
            S_ACT:   value_d = {{(DISP_W-4){1'b0}}, initial_activity_count};
            S_HIGH:  value_d = saturate({3'b000, high_activity_time}, SAT_LIMIT);
            default: value_d = '0;
        endcase
    end

    // State, dwell and display registers; the display refreshes every cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_STEPS;
            dwell_q    <= '0;
            disp_value <= '0;
            disp_dp    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            disp_value <= value_d;
            disp_dp    <= dp_d;
        end
    end

    assign disp_sel = state_q;

endmodule

// File: tb/tb_fitbit_display_sequencer.sv
// Directed bench for the display sequencer with a 4-cycle second and a
// 2-second dwell, so each statistic is shown for 8 cycles.
module tb_fitbit_display_sequencer;

    localparam int unsigned TPS   = 4;
    localparam int unsigned DWELL = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        HOLD;
    logic [31:0] step_count;
    logic [31:0] distance_covered;
    logic [3:0]  initial_activity_count;
    logic [31:0] high_activity_time;
    logic [13:0] disp_value;
    logic [1:0]  disp_sel;
    logic        disp_dp;
    logic        sec_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fitbit_display_sequencer #(
        .TICKS_PER_SEC(TPS),
        .DWELL_SEC    (DWELL),
        .SAT_MAX      (9999)
    ) dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .HOLD                   (HOLD),
        .step_count             (step_count),
        .distance_covered       (distance_covered),
        .initial_activity_count (initial_activity_count),
        .high_activity_time     (high_activity_time),
        .disp_value             (disp_value),
        .disp_sel               (disp_sel),
        .disp_dp                (disp_dp),
        .sec_tick               (sec_tick)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    // Compare one observed value with its expected value and count it
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Drive the four statistic inputs
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                                 input logic [3:0] a, input logic [31:0] h);
        step_count             = s;
        distance_covered       = d;
        initial_activity_count = a;
        high_activity_time     = h;
    endtask

    // Advance one clock and settle just past the edge
    task automatic stepCycle();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // One reset edge; cycle 0 is the cycle right after it
    task automatic applyReset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        HOLD  = 1'b0;
        cyc   = 0;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) stepCycle();
    endtask

    int exp_val [4];
    int sel;

    initial begin
        RESET = 1'b0;
        HOLD  = 1'b0;
        applyStimulus(32'd123, 32'd7, 4'd9, 32'd60);
        exp_val[0] = 123;
        exp_val[1] = 35;
        exp_val[2] = 9;
        exp_val[3] = 60;

        // ---- reset state and full rotation ----
        applyReset();
        checkOutput("rst_val",  32'(disp_value), 32'd0);
        checkOutput("rst_sel",  32'(disp_sel),   32'd0);
        checkOutput("rst_dp",   32'(disp_dp),    32'd0);
        checkOutput("rst_tick", 32'(sec_tick),   32'd0);
        for (int c = 1; c <= 34; c++) begin
            runTo(c);
            sel = ((c - 1) / 8) % 4;
            checkOutput("rot_sel",  32'(disp_sel),   32'(sel));
            checkOutput("rot_val",  32'(disp_value), 32'(exp_val[sel]));
            checkOutput("rot_dp",   32'(disp_dp),    32'(sel == 1));
            checkOutput("rot_tick", 32'(sec_tick),   32'(c % 4 == 0));
        end

        // ---- saturation ----
        applyStimulus(32'd10000, 32'd2000, 4'd9, 32'd10000);
        applyReset();
        runTo(1);
        checkOutput("sat_steps", 32'(disp_value), 32'd9999);
        runTo(9);
        checkOutput("sat_dist_sel", 32'(disp_sel),   32'd1);
        checkOutput("sat_dist2000", 32'(disp_value), 32'd9999);
        applyStimulus(32'd10000, 32'hFFFF_FFFF, 4'd9, 32'd10000);
        runTo(10);
        checkOutput("sat_dist_max", 32'(disp_value), 32'd9999);
        applyStimulus(32'd10000, 32'h3333_3334, 4'd9, 32'd10000);
        runTo(11);
        checkOutput("sat_dist_nowrap", 32'(disp_value), 32'd9999);
        applyStimulus(32'd10000, 32'd1999, 4'd9, 32'd10000);
        runTo(12);
        checkOutput("dist_1999", 32'(disp_value), 32'd9995);
        checkOutput("dist_dp",   32'(disp_dp),    32'd1);
        runTo(25);
        checkOutput("sat_high_sel", 32'(disp_sel),   32'd3);
        checkOutput("sat_high",     32'(disp_value), 32'd9999);
        checkOutput("high_dp",      32'(disp_dp),    32'd0);
        applyStimulus(32'd10000, 32'd1999, 4'd9, 32'd9999);
        runTo(26);
        checkOutput("high_9999", 32'(disp_value), 32'd9999);
        applyStimulus(32'd10000, 32'd1999, 4'd9, 32'd9998);
        runTo(27);
        checkOutput("high_9998", 32'(disp_value), 32'd9998);

        // ---- HOLD in S_ACT ----
        applyStimulus(32'd123, 32'd7, 4'd9, 32'd60);
        applyReset();
        runTo(17);
        checkOutput("hold_enter_act", 32'(disp_sel), 32'd2);
        runTo(21);
        HOLD = 1'b1;
        runTo(25);
        checkOutput("hold_sel_25", 32'(disp_sel), 32'd2);
        runTo(30);
        applyStimulus(32'd123, 32'd7, 4'd5, 32'd60);
        runTo(31);
        checkOutput("hold_sel_31", 32'(disp_sel),   32'd2);
        checkOutput("hold_act_upd", 32'(disp_value), 32'd5);
        runTo(41);
        checkOutput("hold_sel_41", 32'(disp_sel), 32'd2);
        HOLD = 1'b0;
        runTo(44);
        checkOutput("resume_sel_44", 32'(disp_sel), 32'd2);
        runTo(45);
        checkOutput("resume_sel_45", 32'(disp_sel),   32'd3);
        checkOutput("resume_val_45", 32'(disp_value), 32'd60);

        // ---- reset mid-rotation with HOLD high ----
        runTo(46);
        HOLD = 1'b1;
        runTo(47);
        applyReset();
        checkOutput("mid_rst_sel", 32'(disp_sel),   32'd0);
        checkOutput("mid_rst_val", 32'(disp_value), 32'd0);
        runTo(1);
        checkOutput("mid_rst_steps", 32'(disp_value), 32'd123);
        runTo(4);
        checkOutput("mid_rst_tick", 32'(sec_tick), 32'd1);
        runTo(8);
        checkOutput("mid_rst_sel_8", 32'(disp_sel), 32'd0);
        runTo(9);
        checkOutput("mid_rst_sel_9", 32'(disp_sel), 32'd1);

        // ---- live step updates ----
        applyReset();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(32'(500 + k), 32'd7, 4'd9, 32'd60);
            stepCycle();
            checkOutput("live_steps", 32'(disp_value), 32'(500 + k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fitbit_display_sequencer.md
Name: fitbit_display_sequencer

Overview:
- Rotates the four fitbit statistics onto the shared 4-digit seven-segment display path, one statistic at a time, for a fixed dwell period each.
- Sits between the fitbit step/activity counters and the display driver.
- Owns the 1 Hz time base, the rotation state machine, value saturation and distance formatting.
- The display driver sees one registered 14-bit value plus a selector and a decimal-point enable.

Parameters:
- TICKS_PER_SEC, 100000000, CLK cycles per one-second tick (benches use 4).
- DWELL_SEC, 2, seconds each statistic stays on the display (must be ≥1).
- SAT_MAX, 9999, largest displayable value; larger inputs clamp to this.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- HOLD  input  1  freezes rotation on the current statistic while high; display value keeps refreshing.
- step_count  input  32  total steps.
- distance_covered  input  32  distance in half-mile units.
- initial_activity_count  input  4  count of early minutes over the activity threshold.
- high_activity_time  input  32  seconds of high activity.
- disp_value  output  14  binary value for the display driver, 0..SAT_MAX.
- disp_sel  output  2  0=steps, 1=distance, 2=activity count, 3=high-activity time.
- disp_dp  output  1  decimal point enable for the tenths digit.
- sec_tick  output  1  one-cycle pulse every TICKS_PER_SEC cycles; shared time base.

Behaviour:
- Reset values (sync, RESET high at posedge): disp_value=0, disp_sel=0, disp_dp=0, sec_tick=0, tick counter=0, dwell counter=0, state=S_STEPS.
- Tick counter counts 0..TICKS_PER_SEC-1.
  - sec_tick is high for exactly the cycle after the counter wraps from TICKS_PER_SEC-1 to 0.
  - First sec_tick is asserted TICKS_PER_SEC cycles after reset release.
  - The tick counter runs regardless of HOLD.
- FSM states: S_STEPS → S_DIST → S_ACT → S_HIGH → S_STEPS, in that order.
  - The dwell counter increments on each sec_tick.
  - When a sec_tick arrives with dwell = DWELL_SEC-1 and HOLD=0, the FSM advances and dwell clears to 0.
  - When HOLD=1, sec_tick does not advance the dwell counter or the state; the dwell counter holds.
  - After HOLD deasserts, rotation resumes with the remaining dwell.
- disp_sel is the state encoding, registered; it changes the cycle after the advancing sec_tick.
- disp_value is registered and has 1-cycle latency from the inputs and the state; it refreshes every cycle, not only on state entry.
  - S_STEPS: min(step_count, SAT_MAX).
  - S_DIST: min(distance_covered*5, SAT_MAX), i.e. tenths of a mile. Compute in at least 35 bits so large inputs clamp instead of wrapping.
  - S_ACT: zero-extended initial_activity_count.
  - S_HIGH: min(high_activity_time, SAT_MAX).
- disp_dp is 1 only in S_DIST, with the same timing as disp_value.
- When the state changes, disp_value and disp_sel update in the same cycle, so the display never shows a mismatched value/selector pair.
- Reset mid-rotation returns to S_STEPS with the dwell and tick counters cleared; the next advance occurs DWELL_SEC*TICKS_PER_SEC cycles later.
- RESET and HOLD high together: RESET wins.

Decomposition:
- Shared fitbit package holds:
  - the state/selector encodings S_STEPS=0, S_DIST=1, S_ACT=2, S_HIGH=3;
  - SAT_MAX;
  - the half-mile-to-tenths factor of 5.
- One sub-module, fitbit_sec_timer, contains the TICKS_PER_SEC counter and sec_tick generation. The activity logic reuses it as its time base.
- Saturation and formatting stay in this module.

Test Plan:
- Reset then idle (TICKS_PER_SEC=4, DWELL_SEC=2), step_count=123:
  - disp_sel=0 and disp_value=123 one cycle after reset release;
  - sec_tick pulses at cycles 4, 8, 12…;
  - disp_sel becomes 1 one cycle after the 2nd tick.
- Full rotation with distance_covered=7, initial_activity_count=9, high_activity_time=60:
  - the sequence is sel 0→1→2→3→0, every 8 cycles;
  - values are step_count, 35 with dp=1, 9, then 60;
  - dp=0 in every state other than 1.
- Saturation:
  - step_count=10000 gives 9999;
  - distance_covered=2000 gives 9999 (not 10000);
  - distance_covered=32'hFFFFFFFF gives 9999 (no wrap);
  - high_activity_time=9999 gives 9999.
- HOLD:
  - assert HOLD in S_ACT after 1 dwell tick and keep it high for 5 ticks: sel stays 2;
  - disp_value still tracks an activity-count change within 1 cycle;
  - after release, advance to sel=3 on the next tick.
- Reset mid-operation: RESET pulsed for 1 cycle in S_HIGH with HOLD=1 → sel=0, value=steps, and next advance exactly 8 cycles after release.
- Live update: step_count incremented every cycle in S_STEPS → disp_value equals the previous cycle's step_count on each cycle.
